gpio_bus_master: RTL

Bus initiator for the 2-bit-address GPIO peripheral bus (A, WE, WD, RD). It turns single host requests (valid/ready) into one-cycle bus transactions and returns a response. It can also poll GPI1 (address 0) on its own timer and flag any change. It sits between the processor-side request path and the GPIO responder, and owns the peripheral bus on its behalf.

---
 rtl/gpio_bus_master_pkg.sv | 21 ++
 rtl/gpio_poll_timer.sv | 33 +++
 rtl/gpio_bus_master.sv | 103 ++++++++++
 3 files changed

// File: rtl/gpio_bus_master_pkg.sv
// rtl/gpio_bus_master_pkg.sv - shared constants and state encoding for the GPIO bus master
package gpio_bus_master_pkg;

    localparam logic [1:0] ADDR_GPI1 = 2'd0;
    localparam logic [1:0] ADDR_GPI2 = 2'd1;
    localparam logic [1:0] ADDR_GPO1 = 2'd2;
    localparam logic [1:0] ADDR_GPO2 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2,
        PBUS = 2'd3
    } state_t;

    // Inputs are read-only at the responder; writes there are dropped.
    function automatic logic is_input_addr(input logic [1:0] addr);
        return addr < ADDR_GPO1;
    endfunction

endpackage

// File: rtl/gpio_poll_timer.sv
// rtl/gpio_poll_timer.sv - free-running GPI1 poll timer with a single pending flag
module gpio_poll_timer #(
    parameter int POLL_DIV = 1000,
    parameter int CW       = 20
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic poll_en,
    input  logic poll_take,
    output logic poll_pending
);

    localparam logic [CW-1:0] RELOAD = CW'(POLL_DIV - 1);

    logic [CW-1:0] counter;

    // A new expiry wins over a same-cycle take so no poll interval is lost.
    always_ff @(posedge CLK) begin
        if (!RST_N || !poll_en) begin
            counter      <= RELOAD;
            poll_pending <= 1'b0;
        end else if (counter == '0) begin
            counter      <= RELOAD;
            poll_pending <= 1'b1;
        end else begin
            counter <= counter - 1'b1;
            if (poll_take) begin
                poll_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gpio_bus_master.sv
// rtl/gpio_bus_master.sv - host-to-GPIO-bus initiator with automatic GPI1 change polling
module gpio_bus_master
    import gpio_bus_master_pkg::*;
#(
    parameter int POLL_DIV = 1000,
    parameter int CW       = 20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        poll_en,
    output logic [31:0] poll_last,
    output logic        chg_pulse,
    output logic [1:0]  A,
    output logic        WE,
    output logic [31:0] WD,
    input  logic [31:0] RD
);

    state_t state;
    logic   poll_pending;
    logic   poll_take;

    assign req_ready = (state == IDLE);
    // Host requests have priority; a poll is only taken on an idle edge without one.
    assign poll_take = (state == IDLE) && !req_valid && poll_pending;

    gpio_poll_timer #(
        .POLL_DIV (POLL_DIV),
        .CW       (CW)
    ) u_poll_timer (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .poll_en      (poll_en),
        .poll_take    (poll_take),
        .poll_pending (poll_pending)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            A         <= ADDR_GPI1;
            WE        <= 1'b0;
            WD        <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            poll_last <= '0;
            chg_pulse <= 1'b0;
        end else begin
            chg_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        A     <= req_addr;
                        WE    <= req_we;
                        WD    <= req_wdata;
                        state <= BUS;
                    end else if (poll_pending) begin
                        A     <= ADDR_GPI1;
                        WE    <= 1'b0;
                        state <= PBUS;
                    end
                end
                BUS: begin
                    rsp_rdata <= WE ? 32'h0 : RD;
                    rsp_err   <= WE && is_input_addr(A);
                    rsp_valid <= 1'b1;
                    A         <= ADDR_GPI1;
                    WE        <= 1'b0;
                    WD        <= '0;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                PBUS: begin
                    if (RD != poll_last) begin
                        poll_last <= RD;
                        chg_pulse <= 1'b1;
                    end
                    A     <= ADDR_GPI1;
                    WE    <= 1'b0;
                    WD    <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
